move_checker: RTL

Parametrised successor to the single-move checker in the Bop-it game datapath. It captures one target move (switch toggles plus button presses), watches the player inputs for a programmable window, and reports pass or fail through a one-cycle `ready` pulse. The result is held until the next round. It sits between the move generator / difficulty logic and the game FSM, which issues `start` and consumes `ready`/`correct`.

---
 rtl/bopit_pkg.sv | 14 +
 rtl/move_input_tracker.sv | 68 ++++++
 rtl/move_checker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bopit_pkg.sv
// Shared Bop-it definitions: move checker FSM states and default datapath sizes.
package bopit_pkg;

    localparam int unsigned BOPIT_NUM_SW  = 8;
    localparam int unsigned BOPIT_NUM_BTN = 5;
    localparam int unsigned BOPIT_CNT_W   = 29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        DONE   = 2'd2
    } move_chk_state_t;

endpackage

// File: rtl/move_input_tracker.sv
// Player input tracker for the move checker.
// Holds the switch baseline (sw_prev) and the accumulated button presses (btn_acc)
// for one round, and compares them against the captured move.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear_i      - round start: load baseline from sw_i, clear btn_acc
//   en_i         - accumulate btn_i into btn_acc this cycle
//   sw_i, btn_i  - live player inputs
//   move_sw_i    - switch bits that must end up toggled
//   move_btn_i   - buttons that must have been pressed
//   match_o      - exact match of toggles and accumulated presses with the move
//   illegal_o    - a pressed button or toggled switch not part of the move
//                  (only with MOVE_CHK_EARLY_EXIT_EN, else constant 0)
module move_input_tracker
    import bopit_pkg::*;
#(
    parameter int unsigned NUM_SW  = BOPIT_NUM_SW,
    parameter int unsigned NUM_BTN = BOPIT_NUM_BTN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic [NUM_SW-1:0]  move_sw_i,
    input  logic [NUM_BTN-1:0] move_btn_i,
    output logic               match_o,
    output logic               illegal_o
);

    logic [NUM_SW-1:0]  sw_prev_q, sw_prev_d;
    logic [NUM_BTN-1:0] btn_acc_q, btn_acc_d;
    logic [NUM_SW-1:0]  sw_diff;

    always_comb begin
        sw_prev_d = sw_prev_q;
        btn_acc_d = btn_acc_q;
        if (clear_i) begin
            sw_prev_d = sw_i;
            btn_acc_d = '0;
        end else if (en_i) begin
            btn_acc_d = btn_acc_q | btn_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_prev_q <= '0;
            btn_acc_q <= '0;
        end else begin
            sw_prev_q <= sw_prev_d;
            btn_acc_q <= btn_acc_d;
        end
    end

    // A switch toggled an even number of times reads as untoggled.
    assign sw_diff = sw_i ^ sw_prev_q;
    assign match_o = (sw_diff == move_sw_i) && (btn_acc_q == move_btn_i);

`ifdef MOVE_CHK_EARLY_EXIT_EN
    assign illegal_o = (|(btn_i & ~move_btn_i)) || (|(sw_diff & ~move_sw_i));
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/move_checker.sv
// Bop-it move checker: captures a target move on start, watches the player
// inputs for play_freq cycles and reports the verdict with a one-cycle ready
// pulse. Verdict, elapsed count and halfway flag are held until the next start.
//
// Optional feature macro: MOVE_CHK_EARLY_EXIT_EN - end the round as soon as an
// input outside the move is seen (sets wrong_input).
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - begin a new round (wins over everything, even mid-window)
//   play_freq    - window length in cycles, sampled on start
//   move_sw      - switch bits to toggle, sampled on start
//   move_btn     - buttons to press, sampled on start
//   sw, btn      - live player inputs (synchronised/debounced upstream)
//   busy         - high while the window is open
//   halfway      - window midpoint reached
//   ready        - one-cycle verdict pulse
//   correct      - verdict
//   wrong_input  - round ended early on an illegal input
//   elapsed      - counter value at the verdict
module move_checker
    import bopit_pkg::*;
#(
    parameter int unsigned NUM_SW  = BOPIT_NUM_SW,
    parameter int unsigned NUM_BTN = BOPIT_NUM_BTN,
    parameter int unsigned CNT_W   = BOPIT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   play_freq,
    input  logic [NUM_SW-1:0]  move_sw,
    input  logic [NUM_BTN-1:0] move_btn,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    output logic               busy,
    output logic               halfway,
    output logic               ready,
    output logic               correct,
    output logic               wrong_input,
    output logic [CNT_W-1:0]   elapsed
);

    move_chk_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [NUM_SW-1:0]  move_sw_q, move_sw_d;
    logic [NUM_BTN-1:0] move_btn_q, move_btn_d;
    logic               halfway_q, halfway_d;
    logic               ready_q, ready_d;
    logic               correct_q, correct_d;
    logic               wrong_q, wrong_d;
    logic [CNT_W-1:0]   elapsed_q, elapsed_d;

    logic acc_en;
    logic match;
    logic illegal;

    move_input_tracker #(
        .NUM_SW  (NUM_SW),
        .NUM_BTN (NUM_BTN)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (start),
        .en_i       (acc_en),
        .sw_i       (sw),
        .btn_i      (btn),
        .move_sw_i  (move_sw_q),
        .move_btn_i (move_btn_q),
        .match_o    (match),
        .illegal_o  (illegal)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        limit_d    = limit_q;
        move_sw_d  = move_sw_q;
        move_btn_d = move_btn_q;
        halfway_d  = halfway_q;
        ready_d    = 1'b0;
        correct_d  = correct_q;
        wrong_d    = wrong_q;
        elapsed_d  = elapsed_q;
        acc_en     = 1'b0;

        if (start) begin
            // Restart suppresses any verdict due this cycle.
            state_d    = WINDOW;
            cnt_d      = '0;
            limit_d    = play_freq;
            move_sw_d  = move_sw;
            move_btn_d = move_btn;
            halfway_d  = 1'b0;
            correct_d  = 1'b0;
            wrong_d    = 1'b0;
            elapsed_d  = '0;
        end else begin
            case (state_q)
                WINDOW: begin
                    if (illegal) begin
                        // Early fail outranks a verdict on the same cycle.
                        state_d   = DONE;
                        ready_d   = 1'b1;
                        correct_d = 1'b0;
                        wrong_d   = 1'b1;
                        elapsed_d = cnt_q;
                    end else if (cnt_q == limit_q) begin
                        // Buttons on the verdict cycle are not counted.
                        state_d   = DONE;
                        ready_d   = 1'b1;
                        correct_d = match;
                        elapsed_d = cnt_q;
                    end else begin
                        acc_en = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == (limit_q >> 1)) begin
                            halfway_d = 1'b1;
                        end
                    end
                end
                default: ; // IDLE and DONE hold until start
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            limit_q    <= '0;
            move_sw_q  <= '0;
            move_btn_q <= '0;
            halfway_q  <= 1'b0;
            ready_q    <= 1'b0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
            elapsed_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            limit_q    <= limit_d;
            move_sw_q  <= move_sw_d;
            move_btn_q <= move_btn_d;
            halfway_q  <= halfway_d;
            ready_q    <= ready_d;
            correct_q  <= correct_d;
            wrong_q    <= wrong_d;
            elapsed_q  <= elapsed_d;
        end
    end

    assign busy        = (state_q == WINDOW);
    assign halfway     = halfway_q;
    assign ready       = ready_q;
    assign correct     = correct_q;
    assign wrong_input = wrong_q;
    assign elapsed     = elapsed_q;

endmodule
